// File: rtl/gradient_solve.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gradient_solve
// Purpose  : Normalised position of val_in inside [min_val, max_val] as an
//            unsigned Q.14 fraction, clamped to [0,1]. The fraction comes
//            from a 14-step restoring divider.
// Revision : 1.0  initial release
// ============================================================================
module gradient_solve (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] min_val,
  input  logic [15:0] max_val,
  input  logic [15:0] val_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] gradient
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    DIV    = 3'd2,
    FINISH = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic [15:0] GRAD_ZERO    = 16'h0000;
  localparam logic [15:0] GRAD_ONE     = 16'h4000;
  localparam logic [3:0]  DIV_LAST_CNT = 4'd13;

  state_t             state;
  logic signed [16:0] num;
  logic signed [16:0] den;
  logic        [17:0] rem;
  logic        [13:0] quot;
  logic        [3:0]  cnt;
  logic        [15:0] result;

  logic signed [16:0] num_n;
  logic signed [16:0] den_n;
  logic        [17:0] rem_sh;
  logic        [17:0] den_ext;
  logic               sub_ok;
  logic        [17:0] rem_nx;
  logic        [13:0] quot_nx;

  // Sign-normalise the captured operands so the divisor is never negative.
  always_comb begin
    num_n = num;
    den_n = den;
    if (den[16]) begin
      num_n = -num;
      den_n = -den;
    end
  end

  // One restoring-division step. After SETUP den holds the positive
  // divisor and rem < den, so the doubled remainder always fits 18 bits.
  always_comb begin
    rem_sh  = rem << 1;
    den_ext = {1'b0, den};
    sub_ok  = (rem_sh >= den_ext);
    rem_nx  = sub_ok ? (rem_sh - den_ext) : rem_sh;
    quot_nx = (quot << 1) | {13'd0, sub_ok};
  end

  // Control FSM plus datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      num      <= '0;
      den      <= '0;
      rem      <= '0;
      quot     <= '0;
      cnt      <= '0;
      result   <= GRAD_ZERO;
      busy     <= 1'b0;
      done     <= 1'b0;
      gradient <= GRAD_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num   <= $signed({val_in[15], val_in}) - $signed({min_val[15], min_val});
            den   <= $signed({max_val[15], max_val}) - $signed({min_val[15], min_val});
            busy  <= 1'b1;
            state <= SETUP;
          end
        end

        SETUP: begin
          if (den_n == 17'sd0) begin
            result <= GRAD_ZERO;
            state  <= FINISH;
          end else if (num_n <= 17'sd0) begin
            result <= GRAD_ZERO;
            state  <= FINISH;
          end else if (num_n >= den_n) begin
            result <= GRAD_ONE;
            state  <= FINISH;
          end else begin
            rem   <= {1'b0, num_n};
            den   <= den_n;
            quot  <= '0;
            cnt   <= DIV_LAST_CNT;
            state <= DIV;
          end
        end

        DIV: begin
          rem  <= rem_nx;
          quot <= quot_nx;
          if (cnt == 4'd0) begin
            result <= {2'b00, quot_nx};
            state  <= FINISH;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        FINISH: begin
          gradient <= result;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= HOLD;
        end

        HOLD: begin
          // A new request needs start to drop first, so a held start
          // never re-triggers.
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gradient_solve.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gradient_solve
// Purpose  : Self-checking bench for gradient_solve against an arithmetic
//            reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_gradient_solve;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] min_val;
  logic [15:0] max_val;
  logic [15:0] val_in;
  logic        busy;
  logic        done;
  logic [15:0] gradient;

  int tests;
  int fails;

  gradient_solve dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .min_val  (min_val),
    .max_val  (max_val),
    .val_in   (val_in),
    .busy     (busy),
    .done     (done),
    .gradient (gradient)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (tests=%0d failed=%0d)", tests, fails);
    $fatal(1, "watchdog");
  end

  // Reference: clamped (val-min)/(max-min) in Q.14, truncated.
  function automatic logic [15:0] model_grad(input logic [15:0] mn, input logic [15:0] mx,
                                             input logic [15:0] v);
    int n, d;
    n = int'($signed(v)) - int'($signed(mn));
    d = int'($signed(mx)) - int'($signed(mn));
    if (d < 0) begin
      n = -n;
      d = -d;
    end
    if (d == 0 || n <= 0) return 16'h0000;
    if (n >= d) return 16'h4000;
    return 16'((n * 16384) / d);
  endfunction

  // Reference: cycles from capture to done (2 when clamped, else 16).
  function automatic int model_lat(input logic [15:0] mn, input logic [15:0] mx,
                                   input logic [15:0] v);
    int n, d;
    n = int'($signed(v)) - int'($signed(mn));
    d = int'($signed(mx)) - int'($signed(mn));
    if (d < 0) begin
      n = -n;
      d = -d;
    end
    if (d == 0 || n <= 0 || n >= d) return 2;
    return 16;
  endfunction

  // Stimulus: raise start with operands, wait (bounded) for done.
  // lat counts edges after the capture edge until done is seen.
  task automatic run_op(input logic [15:0] mn, input logic [15:0] mx, input logic [15:0] v,
                        input bit scramble, output logic [15:0] g, output int lat,
                        output bit ok);
    min_val = mn;
    max_val = mx;
    val_in  = v;
    start   = 1'b1;
    lat     = 0;
    ok      = 1'b0;
    @(posedge clk); #1;
    if (scramble) begin
      min_val = 16'($urandom);
      max_val = 16'($urandom);
      val_in  = 16'($urandom);
    end
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
    g = gradient;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    min_val = 16'h0000; max_val = 16'h0100; val_in = 16'h0080;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL reset_done: got %b expected 0", done);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    tests++;
    if (gradient !== 16'h0000) begin
      fails++; $display("FAIL reset_gradient: got %h expected 0000", gradient);
    end
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] mn [6] = '{16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0050, 16'h0000};
    logic [15:0] mx [6] = '{16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0050, 16'h0003};
    logic [15:0] vv [6] = '{16'h0080, 16'h0040, 16'hFF80, 16'h0200, 16'h0050, 16'h0001};
    logic [15:0] eg [6] = '{16'h2000, 16'h3000, 16'h0000, 16'h4000, 16'h0000, 16'h1555};
    int          el [6] = '{16, 16, 2, 2, 2, 16};
    logic [15:0] g;
    int lat;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      run_op(mn[k], mx[k], vv[k], 1'b0, g, lat, ok);
      tests++;
      if (!ok) begin
        fails++; $display("FAIL dir%0d_timeout: done not seen within 40 cycles", k);
      end
      tests++;
      if (g !== eg[k]) begin
        fails++; $display("FAIL dir%0d_gradient: got %h expected %h", k, g, eg[k]);
      end
      tests++;
      if (lat !== el[k]) begin
        fails++; $display("FAIL dir%0d_latency: got %0d expected %0d", k, lat, el[k]);
      end
      tests++;
      if (busy !== 1'b0) begin
        fails++; $display("FAIL dir%0d_busy_hold: got %b expected 0", k, busy);
      end
      start = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0) begin
        fails++; $display("FAIL dir%0d_done_clear: got %b expected 0", k, done);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] mn, mx, v, g, eg;
    int lat, el;
    bit ok;
    for (int k = 0; k < 60; k++) begin
      mn = 16'($urandom);
      if (k % 2 == 0) begin
        // narrow ranges around min make the non-clamped division common
        mx = mn + 16'($urandom_range(1, 2000));
        v  = mn + 16'($urandom_range(0, 2000));
      end else begin
        mx = 16'($urandom);
        v  = 16'($urandom);
      end
      eg = model_grad(mn, mx, v);
      el = model_lat(mn, mx, v);
      run_op(mn, mx, v, 1'b0, g, lat, ok);
      tests++;
      if (!ok || g !== eg || lat !== el) begin
        fails++;
        $display("FAIL rand%0d: min=%h max=%h val=%h got gradient=%h lat=%0d expected %h lat=%0d",
                 k, mn, mx, v, g, lat, eg, el);
      end
      start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_div();
    logic [15:0] g;
    int lat, seen;
    bit ok;
    run_op(16'h0000, 16'h0100, 16'h0080, 1'b0, g, lat, ok);
    start = 1'b0;
    @(posedge clk); #1;
    min_val = 16'h0000; max_val = 16'h0003; val_in = 16'h0001;
    start = 1'b1;
    @(posedge clk); #1;          // capture edge
    @(posedge clk); #1;          // SETUP -> DIV, first DIV cycle
    repeat (6) @(posedge clk);   // now inside the 7th DIV cycle
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || gradient !== 16'h0000) begin
      fails++;
      $display("FAIL middiv_reset: got done=%b busy=%b gradient=%h expected 0 0 0000",
               done, busy, gradient);
    end
    reset = 1'b1;
    start = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL middiv_no_done: got %0d done cycles expected 0", seen);
    end
    run_op(16'h0000, 16'h0003, 16'h0001, 1'b0, g, lat, ok);
    tests++;
    if (!ok || g !== 16'h1555 || lat !== 16) begin
      fails++;
      $display("FAIL middiv_rerun: got gradient=%h lat=%0d expected 1555 lat=16", g, lat);
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_handshake();
    logic [15:0] g;
    int lat, bad;
    bit ok;
    run_op(16'h0000, 16'h0100, 16'h0080, 1'b1, g, lat, ok);
    tests++;
    if (!ok || g !== 16'h2000 || lat !== 16) begin
      fails++;
      $display("FAIL hs_scrambled: got gradient=%h lat=%0d expected 2000 lat=16", g, lat);
    end
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || busy !== 1'b0 || gradient !== 16'h2000) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL hs_held_start: got %0d bad hold cycles expected 0", bad);
    end
    start = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL hs_done_drop: got %b expected 0", done);
    end
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (gradient !== 16'h2000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL hs_idle_retain: got gradient=%h busy=%b expected 2000 0", gradient, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] g1, g2;
    int lat1, lat2;
    bit ok1, ok2;
    run_op(16'hFF00, 16'h0100, 16'h0000, 1'b0, g1, lat1, ok1);
    start = 1'b0;
    @(posedge clk); #1;
    run_op(16'h0010, 16'h0000, 16'h0020, 1'b0, g2, lat2, ok2);
    tests++;
    if (!ok1 || g1 !== model_grad(16'hFF00, 16'h0100, 16'h0000) || lat1 !== 16) begin
      fails++; $display("FAIL b2b_first: got gradient=%h lat=%0d expected 2000 lat=16", g1, lat1);
    end
    tests++;
    if (!ok2 || g2 !== 16'h0000 || lat2 !== 2) begin
      fails++; $display("FAIL b2b_second: got gradient=%h lat=%0d expected 0000 lat=2", g2, lat2);
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b0;
    start   = 1'b0;
    min_val = 16'h0000;
    max_val = 16'h0000;
    val_in  = 16'h0000;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_div();
    test_handshake();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
